// File: rtl/xreg_file_if.sv
// Bundle between the MEM/WB write-back stage, the decode read ports and the
// integer register file. The register file connects through the slave modport.
interface xreg_file_if #(
  parameter int XLEN           = 32,
  parameter int XREG_ADDRWIDTH = 5
);

  // Write-back bundle from the MEM/WB pipeline register
  logic [XLEN-1:0]           wb_rd_in;
  logic                      wb_rd_en_in;
  logic [XREG_ADDRWIDTH-1:0] wb_rd_addr_in;

  // Decode-stage read ports
  logic                      rs1_en;
  logic [XREG_ADDRWIDTH-1:0] rs1_addr;
  logic [XLEN-1:0]           rs1_data;
  logic                      rs2_en;
  logic [XREG_ADDRWIDTH-1:0] rs2_addr;
  logic [XLEN-1:0]           rs2_data;

  logic [31:0]               wr_count;

  modport master (
    output wb_rd_in, wb_rd_en_in, wb_rd_addr_in,
    output rs1_en, rs1_addr, rs2_en, rs2_addr,
    input  rs1_data, rs2_data, wr_count
  );

  modport slave (
    input  wb_rd_in, wb_rd_en_in, wb_rd_addr_in,
    input  rs1_en, rs1_addr, rs2_en, rs2_addr,
    output rs1_data, rs2_data, wr_count
  );

endinterface

// File: rtl/xreg_file.sv
// Integer register file x0..x31: one write-back port, two combinational read
// ports, x0 hardwired to zero. Define XREG_WB_BYPASS_EN for WB->read forwarding.
module xreg_file #(
  parameter int XLEN           = 32,
  parameter int XREG_ADDRWIDTH = 5,
  parameter int NUM_REGS       = 2 ** XREG_ADDRWIDTH
) (
  input  logic          clk,
  input  logic          rst,
  xreg_file_if.slave    xif
);

  // x0 has no storage; it is synthesised as a constant zero on the read side.
  logic [XLEN-1:0] r_regs [1:NUM_REGS-1];
  logic [31:0]     r_wr_count;

  logic            w_wr_fire;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;

  assign w_wr_fire = xif.wb_rd_en_in && (xif.wb_rd_addr_in != '0);

  // NOTE: the array is cleared by the async reset, so it maps to flops rather
  // than a RAM macro; architectural state must read zero while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_wr_count <= '0;
    end else if (w_wr_fire) begin
      // NOTE: non-blocking assignments keep every reader of r_regs on the
      // pre-edge value, independent of process evaluation order.
      r_regs[xif.wb_rd_addr_in] <= xif.wb_rd_in;
      r_wr_count                <= r_wr_count + 32'd1;
    end
  end

  function automatic logic [XLEN-1:0] read_port(
    input logic                      en,
    input logic [XREG_ADDRWIDTH-1:0] addr,
    input logic                      wr_fire,
    input logic [XREG_ADDRWIDTH-1:0] wr_addr,
    input logic [XLEN-1:0]           wr_data
  );
    logic [XLEN-1:0] data;
    data = '0;
    if (en && (addr != '0)) begin
`ifdef XREG_WB_BYPASS_EN
      if (wr_fire && (addr == wr_addr)) begin
        data = wr_data;
      end else begin
        data = r_regs[addr];
      end
`else
      data = r_regs[addr];
`endif
    end
    return data;
  endfunction

  // NOTE: every output of this block gets a value on every path (the function
  // starts from zero), so no latch is inferred.
  always_comb begin
    w_rs1_data = read_port(xif.rs1_en, xif.rs1_addr, w_wr_fire,
                           xif.wb_rd_addr_in, xif.wb_rd_in);
    w_rs2_data = read_port(xif.rs2_en, xif.rs2_addr, w_wr_fire,
                           xif.wb_rd_addr_in, xif.wb_rd_in);
  end

`ifndef XREG_WB_BYPASS_EN
  // Without forwarding these only qualify the write; the WB->ID hazard is
  // resolved in the pipeline.
  logic w_unused_bypass;
  assign w_unused_bypass = 1'b0;
`endif

  assign xif.rs1_data = w_rs1_data;
  assign xif.rs2_data = w_rs2_data;
  assign xif.wr_count = r_wr_count;

endmodule

// File: tb/tb_xreg_file.sv
// Directed, table-driven bench for xreg_file with hand-written multi-cycle
// sequences for reset, same-cycle read/write, back-to-back and counter wrap.
module tb_xreg_file;

  logic clk;
  logic rst;

  xreg_file_if #(.XLEN(32), .XREG_ADDRWIDTH(5)) xif ();

  xreg_file dut (
    .clk (clk),
    .rst (rst),
    .xif (xif)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  typedef struct {
    string       name;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        rs1_en;
    logic [4:0]  rs1_addr;
    logic        rs2_en;
    logic [4:0]  rs2_addr;
    logic [31:0] exp_rs1;
    logic [31:0] exp_rs2;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive_wb(input logic en, input logic [4:0] addr,
                          input logic [31:0] data);
    xif.wb_rd_en_in   = en;
    xif.wb_rd_addr_in = addr;
    xif.wb_rd_in      = data;
  endtask

  task automatic drive_rd(input logic e1, input logic [4:0] a1,
                          input logic e2, input logic [4:0] a2);
    xif.rs1_en   = e1;
    xif.rs1_addr = a1;
    xif.rs2_en   = e2;
    xif.rs2_addr = a2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_wb(1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] exp_same;

  initial begin
    rst = 1'b1;
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_rd(1'b0, 5'd0, 1'b0, 5'd0);

    // Rows: inputs applied at negedge, outputs compared 1 time unit later,
    // i.e. before the write of that row commits. No row reads the address
    // it writes, so expectations hold with and without forwarding.
    vecs.push_back('{"wr_x5",       1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd6,  1'b1, 5'd0,  32'h0,        32'h0,        32'd0});
    vecs.push_back('{"rd_x5_noen",  1'b0, 5'd5,  32'h12345678, 1'b1, 5'd5,  1'b1, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'd1});
    vecs.push_back('{"wr_x0",       1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd5,  1'b1, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'd1});
    vecs.push_back('{"rd_x0",       1'b1, 5'd6,  32'hCAFEF00D, 1'b1, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0,        32'd1});
    vecs.push_back('{"rs2_dis",     1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  1'b0, 5'd5,  32'hCAFEF00D, 32'h0,        32'd2});
    vecs.push_back('{"wr_x31",      1'b1, 5'd31, 32'hA5A5A5A5, 1'b0, 5'd6,  1'b1, 5'd5,  32'h0,        32'hDEADBEEF,32'd2});
    vecs.push_back('{"rd_x31_x6",   1'b0, 5'd31, 32'h0,        1'b1, 5'd31, 1'b1, 5'd6,  32'hA5A5A5A5, 32'hCAFEF00D, 32'd3});
    vecs.push_back('{"wr_x1",       1'b1, 5'd1,  32'h00000001, 1'b1, 5'd31, 1'b1, 5'd2,  32'hA5A5A5A5, 32'h0,        32'd3});
    vecs.push_back('{"rd_x1_x31",   1'b0, 5'd1,  32'h0,        1'b1, 5'd1,  1'b1, 5'd31, 32'h00000001, 32'hA5A5A5A5, 32'd4});

    #1;
    check("por_rs1", xif.rs1_data, 32'h0);
    check("por_cnt", xif.wr_count, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive_wb(vecs[i].wb_en, vecs[i].wb_addr, vecs[i].wb_data);
      drive_rd(vecs[i].rs1_en, vecs[i].rs1_addr, vecs[i].rs2_en, vecs[i].rs2_addr);
      #1;
      check({vecs[i].name, "_rs1"}, xif.rs1_data, vecs[i].exp_rs1);
      check({vecs[i].name, "_rs2"}, xif.rs2_data, vecs[i].exp_rs2);
      check({vecs[i].name, "_cnt"}, xif.wr_count, vecs[i].exp_cnt);
    end

    // Asynchronous reset between edges: every address reads zero at once.
    @(negedge clk);
    drive_wb(1'b0, 5'd0, 32'h0);
    #2 rst = 1'b1;
    for (int a = 0; a < 32; a++) begin
      drive_rd(1'b1, a[4:0], 1'b1, a[4:0]);
      #1;
      check($sformatf("arst_rs1_x%0d", a), xif.rs1_data, 32'h0);
      check($sformatf("arst_rs2_x%0d", a), xif.rs2_data, 32'h0);
    end
    check("arst_cnt", xif.wr_count, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back writes to x3: last write wins.
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      drive_wb(1'b1, 5'd3, 32'(k));
    end
    @(negedge clk);
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_rd(1'b1, 5'd3, 1'b1, 5'd3);
    #1;
    check("b2b_x3", xif.rs1_data, 32'd3);
    check("b2b_cnt", xif.wr_count, 32'd3);

    // Same-cycle write and read of x7 on both ports.
    @(negedge clk);
    drive_wb(1'b1, 5'd7, 32'h11);
    @(negedge clk);
    drive_wb(1'b1, 5'd7, 32'h22);
    drive_rd(1'b1, 5'd7, 1'b1, 5'd7);
`ifdef XREG_WB_BYPASS_EN
    exp_same = 32'h22;
`else
    exp_same = 32'h11;
`endif
    #1;
    check("wrcyc_rs1_x7", xif.rs1_data, exp_same);
    check("wrcyc_rs2_x7", xif.rs2_data, exp_same);
    @(negedge clk);
    drive_wb(1'b0, 5'd7, 32'h0);
    #1;
    check("next_rs1_x7", xif.rs1_data, 32'h22);
    check("next_rs2_x7", xif.rs2_data, 32'h22);
    check("x7_cnt", xif.wr_count, 32'd5);

    // Reset asserted during a write of x4 aborts it.
    @(negedge clk);
    drive_wb(1'b1, 5'd4, 32'hAA);
    drive_rd(1'b1, 5'd4, 1'b1, 5'd3);
    #10 rst = 1'b1;
    #1;
    check("midrst_cnt_async", xif.wr_count, 32'h0);
    @(negedge clk);
    drive_wb(1'b0, 5'd0, 32'h0);
    rst = 1'b0;
    #1;
    check("midrst_x4", xif.rs1_data, 32'h0);
    check("midrst_x3", xif.rs2_data, 32'h0);
    check("midrst_cnt", xif.wr_count, 32'h0);

    // Counter wrap: deposit all-ones, then one write to x1.
    @(negedge clk);
    force dut.r_wr_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_wr_count;
    drive_wb(1'b1, 5'd1, 32'h77);
    drive_rd(1'b1, 5'd1, 1'b0, 5'd0);
    @(negedge clk);
    drive_wb(1'b0, 5'd0, 32'h0);
    #1;
    check("wrap_cnt", xif.wr_count, 32'h0);
    check("wrap_x1", xif.rs1_data, 32'h77);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/xreg_file.md
Name: xreg_file

Overview:
- General-purpose integer register file (x0..x31) at the receiving end of the write-back interface.
- Consumes the registered write-back bundle (data, enable, address) from the MEM/WB pipeline register.
- Serves two combinational read ports to the decode stage (rs1/rs2).
- Owns architectural register state; x0 is hardwired to zero.

Parameters:
- XLEN, 32, data width of each register and port
- XREG_ADDRWIDTH, 5, register address width
- NUM_REGS, 32, number of architectural registers (2**XREG_ADDRWIDTH)

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset (matches RST_ENABLE)
- wb_rd_in  input  XLEN  write-back data
- wb_rd_en_in  input  1  write-back enable
- wb_rd_addr_in  input  XREG_ADDRWIDTH  write-back destination register
- rs1_en  input  1  read port 1 enable
- rs1_addr  input  XREG_ADDRWIDTH  read port 1 address
- rs1_data  output  XLEN  read port 1 data
- rs2_en  input  1  read port 2 enable
- rs2_addr  input  XREG_ADDRWIDTH  read port 2 address
- rs2_data  output  XLEN  read port 2 data
- wr_count  output  32  count of committed non-x0 writes since reset (debug/perf)

Behaviour:
- Storage: NUM_REGS x XLEN register array.
- Reset: asynchronous, active-high. While rst=1:
  - all registers clear to 0
  - wr_count clears to 0
  - rs1_data and rs2_data read 0 (array is zero)
- Reset asserted mid-operation aborts any write in that cycle; no partial update.
- Write: on posedge clk with rst=0 and wb_rd_en_in=1 and wb_rd_addr_in!=0:
  - reg[wb_rd_addr_in] <= wb_rd_in
  - wr_count increments by 1
- Write to x0 is discarded silently: no array change, no wr_count increment.
- wb_rd_en_in=0 means no state change, regardless of data/address values.
- Write latency: 1 clock. Value is visible on the read ports from the cycle after the edge.
- Read (combinational, same cycle):
  - rsN_en=0 → rsN_data = 0
  - rsN_en=1 and rsN_addr=0 → rsN_data = 0
  - otherwise rsN_data = reg[rsN_addr], or the bypassed value (see Optional Feature)
- Both read ports are independent. Both may read the same address in the same cycle, including while it is being written.
- wr_count: 32-bit unsigned, wraps from 0xFFFFFFFF to 0 with no flag.
- No handshake, no stall: every enabled write is accepted every cycle.
- Back-to-back writes to the same register: last write wins, one write per cycle.

Optional Feature:
- Macro: XREG_WB_BYPASS_EN
- Defined: write-to-read forwarding.
  - If wb_rd_en_in=1, wb_rd_addr_in!=0, rsN_en=1 and rsN_addr==wb_rd_addr_in, then rsN_data = wb_rd_in combinationally, in the same cycle as the write.
  - x0 is never bypassed.
  - Applies to both ports independently.
- Undefined:
  - Reads return the pre-write array contents during the write cycle.
  - The new value is visible only from the following cycle.
  - The pipeline must handle the WB→ID hazard elsewhere.

Test Plan:
- Reset state: assert rst asynchronously between edges, read all 32 addresses on both ports → every read is 0 and wr_count=0 immediately, without waiting for a clock edge.
- Basic write/read: write x5=0xDEADBEEF (en=1) → next cycle rs1_addr=5 gives 0xDEADBEEF and wr_count=1. Then wb_rd_en_in=0 with addr=5, data=0x12345678 → x5 unchanged.
- x0 protection: write x0=0xFFFFFFFF → rs1 and rs2 at addr 0 read 0 and wr_count unchanged. rs2_en=0 with rs2_addr=5 → rs2_data=0.
- Same-cycle read/write of x7 (old 0x11, new 0x22), both ports reading x7:
  - with XREG_WB_BYPASS_EN, both ports show 0x22 in the write cycle
  - without it, both show 0x11 in the write cycle and 0x22 the next cycle
- Back-to-back and reset mid-operation:
  - write x3=1, x3=2, x3=3 on consecutive cycles → x3=3 and wr_count=3
  - assert rst during a write of x4=0xAA → x4=0 and wr_count=0 after release
- Counter wrap: force wr_count to 0xFFFFFFFF via 2^32 writes or a hierarchical deposit, then perform one write to x1 → wr_count=0.
